mux_2_1_exerciser: RTL and testbench
====================================

Name: mux_2_1_exerciser

Overview:
- Self-running stimulus and check stage placed directly upstream of mux_2_1 variants such as mux_2_1_IfElse.
- Drives the mux a/b/s inputs through all 8 {a,b,s} combinations in binary-count order, holding each vector for a programmable number of cycles.
- Samples the mux output on the last cycle of each hold window and checks it against out = s ? b : a.
- Reports mismatch count, first failing vector and run status, so mux variants can be checked in hardware or in a bench without a behavioural stimulus loop.

Parameters:
- HOLD_CYCLES, 4, clock cycles each vector is held; legal range 1..255.
- ERR_W, 8, width of the saturating mismatch counter.
- LOOP, 0, 0 = one pass of 8 vectors then DONE; 1 = wrap from vector 7 to 0 indefinitely.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level; sampled in IDLE or DONE to begin a run.
- pause  in  1  level; freezes the sequencer while high.
- mux_out  in  1  output of the mux under test (combinational from a/b/s).
- a  out  1  mux data input 0; registered.
- b  out  1  mux data input 1; registered.
- s  out  1  mux select; registered.
- vld  out  1  high while a/b/s carry a live vector (state RUN).
- idx  out  3  current vector index; always equals {a,b,s} while vld=1.
- err_cnt  out  ERR_W  saturating mismatch count for the current run.
- first_err_vld  out  1  set at the first mismatch of a run.
- first_err_idx  out  3  idx of the first mismatch; valid when first_err_vld=1.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; only reachable when LOOP=0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - a, b, s, idx, hcnt = 0.
  - vld, busy, done, first_err_vld = 0; err_cnt = 0; first_err_idx = 0.
  - Reset takes effect from any state, including mid-hold; no partial compare is recorded.
- States: IDLE, RUN, DONE; 2-bit encoding from the package.
- IDLE:
  - a/b/s held at 0.
  - start=1 at edge k -> RUN from edge k.
  - Cycle k+1: idx=0, vld=1, hcnt=0, err_cnt=0, first_err_vld=0.
- RUN, hold counter hcnt counts 0..HOLD_CYCLES-1:
  - Compare cycle is hcnt==HOLD_CYCLES-1 with pause=0.
  - On the compare cycle, mux_out is sampled against exp = s ? b : a.
  - On mismatch: err_cnt increments, saturating at 2^ERR_W-1. If first_err_vld=0, set it and capture first_err_idx=idx.
  - After the compare, hcnt goes to 0 and idx increments.
  - idx=7 compare with LOOP=0: next state DONE, vld=0, a/b/s return to 0.
  - idx=7 compare with LOOP=1: idx wraps to 0; err_cnt and first_err are NOT cleared.
- HOLD_CYCLES=1: every RUN cycle is a compare cycle. a/b/s are registered, so mux_out is settled within the cycle.
- Pause:
  - pause=1 in RUN freezes hcnt, idx and a/b/s, and suppresses the compare.
  - vld stays 1.
  - Pause in IDLE or DONE has no effect.
- start while in RUN is ignored.
- DONE:
  - done=1, holding all result outputs.
  - start=1 -> RUN with counters cleared exactly as from IDLE; done drops the next cycle.
- Timing, LOOP=0 and no pause: done rises 8*HOLD_CYCLES+1 cycles after the start edge.
- Simultaneous events:
  - rst beats start and pause.
  - pause beats the compare on the same cycle.

Decomposition:
- Package mux_exr_pkg:
  - state enum/localparams ST_IDLE, ST_RUN, ST_DONE.
  - VEC_W=3, NUM_VEC=8.
  - Function mux_exp(a,b,s) returning s ? b : a.
- One sub-module is natural: mux_exr_hold_cnt, the hold counter with pause gating and a compare-strobe output, parameterised by HOLD_CYCLES.
- Sequencer FSM and error logic stay in the top.

Test Plan:
1. Golden mux_2_1_IfElse attached, HOLD_CYCLES=4, LOOP=0, start pulse -> idx steps 0..7 every 4 cycles; done rises 33 cycles after start; err_cnt=0; first_err_vld=0.
2. mux_out tied 0 -> mismatches at idx 3, 4, 6, 7; err_cnt=4; first_err_vld=1; first_err_idx=3.
3. pause high for 10 cycles during idx=2 -> idx and a/b/s frozen, no compare; done delayed to 43 cycles after start; err_cnt=0 with golden mux.
4. rst pulse during idx=5 -> next cycle state IDLE with all outputs 0; new start gives a clean pass with err_cnt=0.
5. LOOP=1, ERR_W=2, mux_out tied 0, 3 passes -> idx wraps 7->0; done never asserts; err_cnt saturates at 3; first_err_idx=3.
6. start re-pulsed during RUN at idx=4 -> ignored, sequence continues; then start in DONE -> err_cnt and first_err_vld cleared; idx=0 on the next cycle.

Source files
------------

// File: rtl/mux_exr_pkg.sv
// Shared types, sizes and the reference mux function for the mux_2_1 exerciser.
package mux_exr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // {a,b,s} is one 3-bit vector, so there are 8 of them.
  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  // Hold counter width; large enough for HOLD_CYCLES up to 255.
  localparam int HCNT_W  = 8;

  // Behaviour every mux_2_1 variant must show.
  function automatic logic mux_exp(input logic a, input logic b, input logic s);
    return s ? b : a;
  endfunction

endpackage

// File: rtl/mux_exr_hold_cnt.sv
// Hold-window counter: counts 0..HOLD_CYCLES-1 while enabled and not paused,
// and strobes cmp_o on the last cycle of each window.
module mux_exr_hold_cnt
  import mux_exr_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic pause_i,
  output logic cmp_o
);

  localparam logic [HCNT_W-1:0] LAST = HCNT_W'(HOLD_CYCLES - 1);

  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] hcnt_d;
  logic              adv;

  // A paused cycle neither advances the window nor counts as a compare.
  assign adv   = en_i && !pause_i;
  assign cmp_o = adv && (hcnt_q == LAST);

  // Next count: restart on a new run or at the end of a window.
  always_comb begin
    hcnt_d = hcnt_q;
    if (clr_i) begin
      hcnt_d = '0;
    end else if (cmp_o) begin
      hcnt_d = '0;
    end else if (adv) begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end

endmodule

// File: rtl/mux_2_1_exerciser.sv
// Self-running stimulus/check stage for mux_2_1 variants: walks {a,b,s}
// through all 8 vectors, checks mux_out at the end of each hold window and
// reports mismatch count, first failing vector and run status.
module mux_2_1_exerciser
  import mux_exr_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8,
  parameter int LOOP        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             mux_out_i,
  output logic             a_o,
  output logic             b_o,
  output logic             s_o,
  output logic             vld_o,
  output logic [VEC_W-1:0] idx_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             first_err_vld_o,
  output logic [VEC_W-1:0] first_err_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  idx_q, idx_d;
  logic [VEC_W-1:0]  abs_q, abs_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fev_q, fev_d;
  logic [VEC_W-1:0]  fei_q, fei_d;
  logic              start_run;
  logic              cmp;
  logic              mismatch;

  // start is only honoured outside RUN.
  assign start_run = start_i && (state_q != ST_RUN);

  mux_exr_hold_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_run),
    .en_i    (state_q == ST_RUN),
    .pause_i (pause_i),
    .cmp_o   (cmp)
  );

  // The driven vector is registered, so mux_out has settled by the compare.
  assign mismatch = mux_out_i != mux_exp(abs_q[2], abs_q[1], abs_q[0]);

  // Sequencer next state, vector stepping and error capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abs_d   = abs_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_RUN;
          idx_d   = '0;
          abs_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fei_d   = '0;
        end
      end
      ST_RUN: begin
        if (cmp) begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = idx_q;
            end
          end
          if ((idx_q == LAST_IDX) && (LOOP == 0)) begin
            state_d = ST_DONE;
            idx_d   = '0;
            abs_d   = '0;
          end else begin
            // Wraps 7 -> 0 naturally in loop mode; results are kept.
            idx_d = idx_q + 1'b1;
            abs_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        abs_d   = '0;
      end
    endcase
  end

  // State and result registers; reset wins over any in-flight window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      abs_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abs_q   <= abs_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
    end
  end

  assign a_o             = abs_q[2];
  assign b_o             = abs_q[1];
  assign s_o             = abs_q[0];
  assign idx_o           = idx_q;
  assign vld_o           = (state_q == ST_RUN);
  assign busy_o          = (state_q == ST_RUN);
  assign done_o          = (state_q == ST_DONE);
  assign err_cnt_o       = err_q;
  assign first_err_vld_o = fev_q;
  assign first_err_idx_o = fei_q;

endmodule

// File: tb/tb_mux_2_1_exerciser.sv
// Bench for mux_2_1_exerciser: a golden (or stuck-at-0) mux closes the loop on
// dut0; dut1 runs in loop mode with a 1-cycle hold against a stuck-at-0 mux.
module tb_mux_2_1_exerciser;

  logic clk;
  logic rst;
  logic start0, start1, pause;
  logic tie0;

  logic       mux_out0, a0, b0, s0, vld0, fev0, busy0, done0;
  logic [2:0] idx0, fei0;
  logic [7:0] err0;

  logic       mux_out1, a1, b1, s1, vld1, fev1, busy1, done1;
  logic [2:0] idx1, fei1;
  logic [1:0] err1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;

  typedef struct {
    logic [2:0] idx;
    int         hold;
  } sb_e;
  sb_e        sbq[$];
  logic       cur_vld = 1'b0;
  logic [2:0] cur_idx = '0;
  int         cur_hold = 0;
  int         hold_cnt = 0;

  // External mux under test: golden mux_2_1 or output stuck at 0.
  assign mux_out0 = tie0 ? 1'b0 : (s0 ? b0 : a0);
  assign mux_out1 = 1'b0;

  mux_2_1_exerciser #(.HOLD_CYCLES(4), .ERR_W(8), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .pause_i(pause), .mux_out_i(mux_out0),
    .a_o(a0), .b_o(b0), .s_o(s0), .vld_o(vld0), .idx_o(idx0), .err_cnt_o(err0),
    .first_err_vld_o(fev0), .first_err_idx_o(fei0), .busy_o(busy0), .done_o(done0)
  );

  mux_2_1_exerciser #(.HOLD_CYCLES(1), .ERR_W(2), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .pause_i(1'b0), .mux_out_i(mux_out1),
    .a_o(a1), .b_o(b1), .s_o(s1), .vld_o(vld1), .idx_o(idx1), .err_cnt_o(err1),
    .first_err_vld_o(fev1), .first_err_idx_o(fei1), .busy_o(busy1), .done_o(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_run(input int pidx, input int extra);
    for (int i = 0; i < 8; i++) begin
      sb_e e;
      e.idx  = 3'(i);
      e.hold = (i == pidx) ? 4 + extra : 4;
      sbq.push_back(e);
    end
  endtask

  task automatic flush_sb();
    sbq.delete();
    cur_vld  = 1'b0;
    hold_cnt = 0;
  endtask

  // Scoreboard monitor for dut0: each new vector pops its expected index and
  // hold length; the previous vector's visible duration is then checked.
  task automatic mon();
    if (vld0) begin
      chk_eq("abs_eq_idx", {29'd0, a0, b0, s0}, {29'd0, idx0});
      if (!cur_vld || idx0 != cur_idx) begin
        if (cur_vld) chk_eq("hold_len", hold_cnt, cur_hold);
        if (sbq.size() == 0) begin
          chk_eq("sb_unexpected_vec", 1, 0);
          cur_hold = 4;
        end else begin
          sb_e e;
          e = sbq.pop_front();
          chk_eq("vec_idx", idx0, e.idx);
          cur_hold = e.hold;
        end
        cur_idx  = idx0;
        cur_vld  = 1'b1;
        hold_cnt = 0;
      end
      hold_cnt++;
    end else begin
      if (cur_vld) chk_eq("hold_len", hold_cnt, cur_hold);
      cur_vld = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic do_start0();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_idx(input logic [2:0] n);
    int g = 0;
    while (!(vld0 && idx0 == n) && g < 200) begin
      step();
      g++;
    end
    chk_eq("wait_idx", {28'd0, vld0, idx0}, {28'd0, 1'b1, n});
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int g = 0;
    while (!done0 && g < 400) begin
      step();
      g++;
    end
    chk_eq(tag, cyc - t0, exp_lat);
  endtask

  task automatic chk_all_zero0(input string tag);
    chk_eq({tag, "_idx"}, idx0, 0);
    chk_eq({tag, "_abs"}, {a0, b0, s0}, 0);
    chk_eq({tag, "_vld"}, vld0, 0);
    chk_eq({tag, "_busy"}, busy0, 0);
    chk_eq({tag, "_done"}, done0, 0);
    chk_eq({tag, "_err"}, err0, 0);
    chk_eq({tag, "_fev"}, fev0, 0);
    chk_eq({tag, "_fei"}, fei0, 0);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; pause = 1'b0; tie0 = 1'b0;
    step();
    step();
    chk_all_zero0("rst");
    chk_eq("rst_vld1", vld1, 0);
    chk_eq("rst_err1", err1, 0);
    rst = 1'b0;
    pause = 1'b1;
    step();
    step();
    pause = 1'b0;
    chk_eq("idle_pause_vld", vld0, 0);
    chk_eq("idle_pause_done", done0, 0);

    // Golden pass.
    push_run(-1, 0);
    do_start0();
    chk_eq("t1_first_idx", idx0, 0);
    chk_eq("t1_busy", busy0, 1);
    wait_done(33, "t1_done_lat");
    chk_eq("t1_err", err0, 0);
    chk_eq("t1_fev", fev0, 0);
    chk_eq("t1_vld", vld0, 0);
    chk_eq("t1_abs", {a0, b0, s0}, 0);
    chk_eq("t1_sb_left", sbq.size(), 0);

    // Stuck-at-0 mux, started from DONE.
    tie0 = 1'b1;
    push_run(-1, 0);
    do_start0();
    chk_eq("t2_done_drop", done0, 0);
    wait_done(33, "t2_done_lat");
    chk_eq("t2_err", err0, 4);
    chk_eq("t2_fev", fev0, 1);
    chk_eq("t2_fei", fei0, 3);

    // Pause in DONE changes nothing.
    pause = 1'b1;
    repeat (3) step();
    pause = 1'b0;
    chk_eq("done_pause_done", done0, 1);
    chk_eq("done_pause_err", err0, 4);
    chk_eq("done_pause_fei", fei0, 3);

    // Restart from DONE clears results; start during RUN is ignored.
    tie0 = 1'b0;
    push_run(-1, 0);
    do_start0();
    chk_eq("t6_idx", idx0, 0);
    chk_eq("t6_err_clr", err0, 0);
    chk_eq("t6_fev_clr", fev0, 0);
    chk_eq("t6_done", done0, 0);
    wait_idx(3'd4);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk_eq("t6_ignored_idx", idx0, 4);
    wait_done(33, "t6_done_lat");
    chk_eq("t6_err", err0, 0);

    // Pause 10 cycles during idx 2, overlapping its compare cycle.
    push_run(2, 10);
    do_start0();
    wait_idx(3'd2);
    repeat (3) step();
    pause = 1'b1;
    repeat (10) step();
    pause = 1'b0;
    chk_eq("t3_frozen_idx", idx0, 2);
    chk_eq("t3_frozen_vld", vld0, 1);
    wait_done(43, "t3_done_lat");
    chk_eq("t3_err", err0, 0);
    chk_eq("t3_fev", fev0, 0);

    // Reset mid-run, with start and pause also high.
    tie0 = 1'b1;
    push_run(-1, 0);
    do_start0();
    wait_idx(3'd5);
    step();
    chk_eq("t4_pre_err", err0, 2);
    rst = 1'b1;
    start0 = 1'b1;
    pause = 1'b1;
    flush_sb();
    step();
    chk_all_zero0("t4_rst");
    rst = 1'b0;
    start0 = 1'b0;
    pause = 1'b0;
    step();
    chk_eq("t4_idle_vld", vld0, 0);
    tie0 = 1'b0;
    push_run(-1, 0);
    do_start0();
    wait_done(33, "t4_done_lat");
    chk_eq("t4_err", err0, 0);
    chk_eq("t4_fev", fev0, 0);

    // Loop mode, 1-cycle hold, stuck-at-0 mux: three passes.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk_eq("t5_idx", idx1, i % 8);
      chk_eq("t5_abs", {a1, b1, s1}, i % 8);
      chk_eq("t5_done", done1, 0);
      step();
    end
    chk_eq("t5_err_sat", err1, 3);
    chk_eq("t5_fev", fev1, 1);
    chk_eq("t5_fei", fei1, 3);
    chk_eq("t5_busy", busy1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
